// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scanner.
// Holds the active-low hex segment encodings (bit0..6 = a..g, bit7 = dp),
// the all-off pattern and the anode ghosting-guard length in clk cycles.
package sevenseg_pkg;

    localparam int unsigned GUARD_LEN = 2;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low encodings with the decimal point off.
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

endpackage

// File: rtl/sevenseg_hex7seg.sv
// Combinational hex-to-seven-segment decoder.
// Ports: nibble (4-bit hex digit), dp (1 = point lit),
//        seg_c (8-bit active-low segments, bit7 = dp).
module hex7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (nibble)
            4'h0:    seg_c = SEG_0;
            4'h1:    seg_c = SEG_1;
            4'h2:    seg_c = SEG_2;
            4'h3:    seg_c = SEG_3;
            4'h4:    seg_c = SEG_4;
            4'h5:    seg_c = SEG_5;
            4'h6:    seg_c = SEG_6;
            4'h7:    seg_c = SEG_7;
            4'h8:    seg_c = SEG_8;
            4'h9:    seg_c = SEG_9;
            4'hA:    seg_c = SEG_A;
            4'hB:    seg_c = SEG_B;
            4'hC:    seg_c = SEG_C;
            4'hD:    seg_c = SEG_D;
            4'hE:    seg_c = SEG_E;
            default: seg_c = SEG_F;
        endcase
        seg_c[7] = ~dp;
    end

endmodule

// File: rtl/sevenseg_scanner.sv
// Multiplexed seven-segment display scanner with PWM dimming,
// leading-zero blanking and per-digit blinking.
// Ports: clk, reset (sync, active-high); value/dots/load feed a shadow
// register copied to the display register each frame; blank_lz,
// brightness, blink_mask are sampled at every digit slot start;
// sevenseg/sevenseg_an are active-low segment/anode drives; frame pulses
// on the last cycle of the last digit's slot.
// All outputs are registered: each is computed from the next-state values
// so it lines up with the counters it describes.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int unsigned NDIGITS      = 4,
    parameter int unsigned SCAN_DIV     = 12500,
    parameter int unsigned BLINK_FRAMES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dots,
    input  logic                   load,
    input  logic                   blank_lz,
    input  logic [3:0]             brightness,
    input  logic [NDIGITS-1:0]     blink_mask,
    output logic [7:0]             sevenseg,
    output logic [NDIGITS-1:0]     sevenseg_an,
    output logic                   frame
);

    localparam int unsigned VAL_W = 4 * NDIGITS;
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_GUARD = DIV_W'(GUARD_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    // State registers
    logic [DIV_W-1:0]   div_cnt,    div_nxt;
    logic [IDX_W-1:0]   idx,        idx_nxt;
    logic [3:0]         pwm_cnt,    pwm_nxt;
    logic [FRM_W-1:0]   frame_cnt,  frame_cnt_nxt;
    logic               blink_phase, blink_nxt;
    logic [VAL_W-1:0]   shadow_val, shadow_val_nxt;
    logic [NDIGITS-1:0] shadow_dots, shadow_dots_nxt;
    logic [VAL_W-1:0]   disp_val,   disp_val_nxt;
    logic [NDIGITS-1:0] disp_dots,  disp_dots_nxt;
    logic [3:0]         slot_bright, slot_bright_nxt;
    logic               slot_dark,  slot_dark_nxt;

    logic [7:0]         seg_nxt;
    logic [NDIGITS-1:0] an_nxt;
    logic               frame_nxt;

    logic               slot_end_c;
    logic               frame_c;

    // Digit selected for the upcoming slot
    logic [3:0]         sel_nib_c;
    logic               sel_dot_c;
    logic               sel_mask_c;
    logic               sel_lz_c;
    logic [7:0]         hex_seg_c;

    // Counters, shadow/display transfer and blink phase
    always_comb begin
        div_nxt         = div_cnt;
        idx_nxt         = idx;
        pwm_nxt         = pwm_cnt + 4'd1;
        frame_cnt_nxt   = frame_cnt;
        blink_nxt       = blink_phase;
        shadow_val_nxt  = shadow_val;
        shadow_dots_nxt = shadow_dots;
        disp_val_nxt    = disp_val;
        disp_dots_nxt   = disp_dots;

        slot_end_c = (div_cnt == DIV_LAST);
        frame_c    = slot_end_c && (idx == IDX_LAST);

        if (slot_end_c) begin
            div_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            div_nxt = div_cnt + DIV_W'(1);
        end

        if (load) begin
            shadow_val_nxt  = value;
            shadow_dots_nxt = dots;
        end

        // Display takes the pre-edge shadow, so a load on a frame cycle waits a frame.
        if (frame_c) begin
            disp_val_nxt  = shadow_val;
            disp_dots_nxt = shadow_dots;
            if (frame_cnt == FRM_LAST) begin
                frame_cnt_nxt = '0;
                blink_nxt     = ~blink_phase;
            end else begin
                frame_cnt_nxt = frame_cnt + FRM_W'(1);
            end
        end
    end

    // Select nibble/dot/mask for idx_nxt; sel_lz_c = no nonzero digit at or above it
    always_comb begin
        sel_nib_c  = 4'h0;
        sel_dot_c  = 1'b0;
        sel_mask_c = 1'b0;
        sel_lz_c   = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                sel_nib_c  = disp_val_nxt[4*i +: 4];
                sel_dot_c  = disp_dots_nxt[i];
                sel_mask_c = blink_mask[i];
            end
            if ((IDX_W'(i) >= idx_nxt) && (disp_val_nxt[4*i +: 4] != 4'h0)) begin
                sel_lz_c = 1'b0;
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble (sel_nib_c),
        .dp     (sel_dot_c),
        .seg_c  (hex_seg_c)
    );

    // Slot-start sampling of segments/brightness/blink, then per-cycle anode gating
    always_comb begin
        slot_bright_nxt = slot_bright;
        slot_dark_nxt   = slot_dark;
        seg_nxt         = sevenseg;
        an_nxt          = '1;

        if (slot_end_c) begin
            slot_bright_nxt = brightness;
            slot_dark_nxt   = blink_nxt && sel_mask_c;
            if (blink_nxt && sel_mask_c) begin
                seg_nxt = SEG_OFF;
            end else if (blank_lz && sel_lz_c && (idx_nxt != '0)) begin
                seg_nxt = {~sel_dot_c, 7'h7F};
            end else begin
                seg_nxt = hex_seg_c;
            end
        end

        if ((div_nxt >= DIV_GUARD) && !slot_dark_nxt &&
            ((slot_bright_nxt == 4'hF) || (pwm_nxt < slot_bright_nxt))) begin
            for (int i = 0; i < NDIGITS; i++) begin
                if (idx_nxt == IDX_W'(i)) begin
                    an_nxt[i] = 1'b0;
                end
            end
        end

        frame_nxt = (div_nxt == DIV_LAST) && (idx_nxt == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow_val  <= '0;
            shadow_dots <= '0;
            disp_val    <= '0;
            disp_dots   <= '0;
            slot_bright <= '0;
            slot_dark   <= 1'b0;
            sevenseg    <= SEG_OFF;
            sevenseg_an <= '1;
            frame       <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            idx         <= idx_nxt;
            pwm_cnt     <= pwm_nxt;
            frame_cnt   <= frame_cnt_nxt;
            blink_phase <= blink_nxt;
            shadow_val  <= shadow_val_nxt;
            shadow_dots <= shadow_dots_nxt;
            disp_val    <= disp_val_nxt;
            disp_dots   <= disp_dots_nxt;
            slot_bright <= slot_bright_nxt;
            slot_dark   <= slot_dark_nxt;
            sevenseg    <= seg_nxt;
            sevenseg_an <= an_nxt;
            frame       <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Self-checking bench for sevenseg_scanner (NDIGITS=4, SCAN_DIV=8,
// BLINK_FRAMES=2). A reference model derives the expected outputs from the
// cycle count since reset using plain division/modulo arithmetic.
module tb_sevenseg_scanner;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BF = 2;
    localparam int FR = ND * SD;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   value = '0;
    logic [3:0]    dots = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [3:0]    brightness = '0;
    logic [3:0]    blink_mask = '0;
    logic [7:0]    sevenseg;
    logic [3:0]    sevenseg_an;
    logic          frame;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int          c = 0;
    logic [15:0] m_shadow = '0, m_disp = '0;
    logic [3:0]  m_sdots = '0, m_ddots = '0;

    sevenseg_scanner #(
        .NDIGITS      (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .dots        (dots),
        .load        (load),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .blink_mask  (blink_mask),
        .sevenseg    (sevenseg),
        .sevenseg_an (sevenseg_an),
        .frame       (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
        end
    endtask

    function automatic logic [7:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic bit dark_at(input int cc);
        int i;
        i = (cc / SD) % ND;
        return (((cc / FR) / BF) % 2 == 1) && blink_mask[i];
    endfunction

    function automatic logic [7:0] exp_seg(input int cc);
        int  i;
        bit  lead;
        logic [7:0] s;
        i = (cc / SD) % ND;
        if (dark_at(cc)) return 8'hFF;
        lead = 1'b1;
        for (int j = i; j < ND; j++)
            if (m_disp[4*j +: 4] != 4'h0) lead = 1'b0;
        if (blank_lz && i != 0 && lead) s = 8'hFF;
        else                            s = hexseg(m_disp[4*i +: 4]);
        if (m_ddots[i]) s[7] = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] exp_an(input int cc);
        int i, d, p;
        logic [3:0] a;
        i = (cc / SD) % ND;
        d = cc % SD;
        p = cc % 16;
        a = 4'hF;
        if (d >= 2 && !dark_at(cc) && (brightness == 4'hF || p < int'(brightness)))
            a[i] = 1'b0;
        return a;
    endfunction

    function automatic logic exp_frame(input int cc);
        return ((cc % SD) == SD - 1) && (((cc / SD) % ND) == ND - 1);
    endfunction

    // Model: cycle count, shadow and display registers
    always @(posedge clk) begin
        if (reset) begin
            c        <= 0;
            m_shadow <= '0;
            m_sdots  <= '0;
            m_disp   <= '0;
            m_ddots  <= '0;
        end else begin
            c <= c + 1;
            if (c % FR == FR - 1) begin
                m_disp  <= m_shadow;
                m_ddots <= m_sdots;
            end
            if (load) begin
                m_shadow <= value;
                m_sdots  <= dots;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("seg",   32'(sevenseg),    32'(exp_seg(c)));
            check("an",    32'(sevenseg_an), 32'(exp_an(c)));
            check("frame", 32'(frame),       32'(exp_frame(c)));
        end
    end

    task automatic set_cfg(input logic [15:0] v, input logic [3:0] d, input logic bl,
                           input logic [3:0] br, input logic [3:0] mk);
        @(negedge clk);
        chk_en     = 1'b0;
        value      = v;
        dots       = d;
        blank_lz   = bl;
        brightness = br;
        blink_mask = mk;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (40) @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic count_active(input string tag, input int exp);
        int n;
        n = 0;
        repeat (FR) begin
            @(negedge clk);
            if (sevenseg_an != 4'hF) n++;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic first_frame_check(input string tag);
        int n;
        n = 1;
        while (frame !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'(FR));
    endtask

    initial begin
        logic [15:0] rv;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg",   32'(sevenseg),    32'hFF);
        check("rst_an",    32'(sevenseg_an), 32'hF);
        check("rst_frame", 32'(frame),       32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_seg",   32'(sevenseg),    32'hFF);
        check("post_rst_an",    32'(sevenseg_an), 32'hF);
        check("post_rst_frame", 32'(frame),       32'h0);
        first_frame_check("first_frame");

        // Basic decode at full brightness, then anode duty at both extremes
        set_cfg(16'h1234, 4'h0, 1'b0, 4'hF, 4'h0);
        repeat (2 * FR) @(negedge clk);
        count_active("active_br15", 24);
        set_cfg(16'h1234, 4'h0, 1'b0, 4'h0, 4'h0);
        count_active("active_br0", 0);

        // Leading-zero blanking with a dot on a blanked digit
        set_cfg(16'h0050, 4'b1000, 1'b1, 4'hF, 4'h0);
        repeat (2 * FR) @(negedge clk);

        // Load on a frame cycle only reaches the display one frame later
        set_cfg(16'h1111, 4'h0, 1'b0, 4'hF, 4'h0);
        repeat (FR) @(negedge clk);
        for (int k = 0; k < FR && (c % FR) != FR - 1; k++) @(negedge clk);
        value = 16'hAAAA;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3 * FR) @(negedge clk);

        // Blink on digit 0 across both phases
        set_cfg(16'h5678, 4'h0, 1'b0, 4'hF, 4'b0001);
        repeat (6 * FR) @(negedge clk);

        // Randomized configurations, with an extra load landing mid-run
        for (int t = 0; t < 10; t++) begin
            rv = 16'($urandom);
            rv = rv >> (4 * $urandom_range(0, 3));
            set_cfg(rv, 4'($urandom), 1'($urandom),
                    (t == 0) ? 4'h0 : (t == 1) ? 4'hF : 4'($urandom), 4'($urandom));
            repeat ($urandom_range(0, FR)) @(negedge clk);
            value = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dots  = 4'($urandom);
            load  = 1'b1;
            @(negedge clk);
            load = 1'b0;
            repeat (4 * FR) @(negedge clk);
        end

        // Reset in the middle of digit 2's slot (div_cnt = 5)
        for (int k = 0; k < FR && (c % FR) != 2 * SD + 5; k++) @(negedge clk);
        chk_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_seg",   32'(sevenseg),    32'hFF);
        check("midrst_an",    32'(sevenseg_an), 32'hF);
        check("midrst_frame", 32'(frame),       32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_after_an", 32'(sevenseg_an), 32'hF);
        first_frame_check("midrst_first_frame");
        chk_en = 1'b1;
        repeat (2 * FR) @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sevenseg_scanner.md
SEVENSEG_SCANNER -- requirements
Module: sevenseg_scanner

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, the number of multiplexed digits (1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 12500, the clk cycles per digit slot (>=4).
REQ-003 SHALL have parameter BLINK_FRAMES, default 256, the frames per blink half-period (>=1).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  sole clock, all logic on posedge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 value  in  4*NDIGITS  hex nibbles; digit i = value[4i+3:4i].
REQ-007 dots  in  NDIGITS  decimal point per digit, 1 = lit.
REQ-008 load  in  1  single-cycle strobe capturing value/dots into shadow register.
REQ-009 blank_lz  in  1  leading-zero blanking enable.
REQ-010 brightness  in  4  PWM duty: 0 = off, 15 = full on, n = n/16.
REQ-011 blink_mask  in  NDIGITS  digits blanked during blink-off phase.
REQ-012 sevenseg  out  8  active-low segments; bit0..6 = a..g, bit7 = dp.
REQ-013 sevenseg_an  out  NDIGITS  active-low anodes; bit i drives digit i.
REQ-014 frame  out  1  one-cycle pulse on the last cycle of digit NDIGITS-1's slot.

Function
REQ-015 Prescaler div_cnt SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index SHALL advance 0->1->...->NDIGITS-1->0.
REQ-016 frame SHALL be 1 exactly when div_cnt = SCAN_DIV-1 and index = NDIGITS-1.
REQ-017 load=1 SHALL copy value/dots into shadow on that edge; display register SHALL copy shadow on every frame cycle using shadow's pre-edge contents (a load on a frame cycle appears one frame later).
REQ-018 sevenseg SHALL update at slot start (div_cnt=0) from the display register nibble of the current index via standard hex decode 0-F.
REQ-019 Anodes SHALL be all-off while div_cnt < 2 (ghosting guard).
REQ-020 Free-running 4-bit pwm_cnt SHALL increment every cycle; anode i SHALL be active when index = i, div_cnt >= 2, and (brightness = 15 or pwm_cnt < brightness).
REQ-021 With blank_lz=1, every zero digit above the most significant nonzero digit SHALL have segments a..g off; digit 0 SHALL never be blanked; its dp SHALL still follow dots.
REQ-022 A frame counter SHALL toggle blink_phase every BLINK_FRAMES frames; while blink_phase=1, digits with blink_mask set SHALL have anode off and sevenseg = 8'hFF.
REQ-023 Counter widths SHALL be $clog2 of their range; all wraps SHALL be modulo, never saturating.
REQ-024 Parameter or input changes other than load SHALL take effect at the next digit slot.

Reset
REQ-025 Reset SHALL clear div_cnt, index, pwm_cnt, frame counter, blink_phase, shadow and display registers.
REQ-026 During and on the cycle after reset, sevenseg SHALL be 8'hFF, sevenseg_an all ones, frame 0.
REQ-027 Reset mid-slot SHALL abort the slot; scanning SHALL restart at digit 0, div_cnt 0.

Structure
REQ-028 Package sevenseg_pkg SHALL hold the 16 segment encoding constants, SEG_OFF = 8'hFF, and the guard length 2.
REQ-029 Combinational sub-module hex7seg (nibble + dp -> 8-bit active-low segments) SHALL be used; everything else lives in sevenseg_scanner.

Verification (NDIGITS=4, SCAN_DIV=8, BLINK_FRAMES=2 unless stated)
REQ-030 Reset, load 16'h1234, dots 0, brightness 15, wait one frame -> slot 0: sevenseg 8'h99, an 4'b1110 for 6 of 8 cycles; slot 1: 8'hB0, an 4'b1101.
REQ-031 blank_lz=1, value 16'h0050 -> digits 3,2: sevenseg 8'hFF; digit 1 8'h92; digit 0 8'hC0; dots=4'b1000 gives digit 3 8'h7F.
REQ-032 brightness 0 -> an all ones for a full frame; brightness 15 -> exactly 24 active-anode cycles per 32-cycle frame.
REQ-033 load 16'hAAAA on a frame cycle after displaying 16'h1111 -> next frame still shows 8'hF9; following frame shows 8'h88.
REQ-034 blink_mask 4'b0001 -> digit 0 lit in frames 0-1, dark (an[0]=1, 8'hFF) in frames 2-3, lit in 4-5; others always lit.
REQ-035 reset asserted at div_cnt=5 of digit 2 -> next cycle 8'hFF/4'b1111, frame=0; scanning resumes at digit 0, first frame pulse 32 cycles after reset release.
